// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard detection, flush-to-NOP and a
// saturating stall counter. PC_write and bubble are combinational from IF/ID and ID/EX.
module if_id_stage #(
   parameter logic [31:0] NOP_WORD = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      Instruction,
   input  logic [31:0]      PC_sumado_value,
   input  logic             flush,
   input  logic             ID_EX_MemRead,
   input  logic [4:0]       ID_EX_rt,
   output logic             PC_write,
   output logic [31:0]      IF_ID_instruction,
   output logic [31:0]      IF_ID_pc_plus4,
   output logic             IF_ID_valid,
   output logic             bubble,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [1:0] ST_FILL  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_STALL = 2'd2;

   logic [1:0]       state_r;
   logic [1:0]       next_state_s;
   logic [31:0]      instr_r;
   logic [31:0]      pc_r;
   logic             valid_r;
   logic [CNT_W-1:0] count_r;
   logic [4:0]       rs_s;
   logic [4:0]       rt_s;
   logic             hz_s;
   logic             stall_s;
   logic             count_max_s;

   assign rs_s        = instr_r[25:21];
   assign rt_s        = instr_r[20:16];
   assign count_max_s = (count_r == {CNT_W{1'b1}});

   // Load-use detection; masked in FILL so the first fetch read is never acted on
   always_comb begin
      hz_s = 1'b0;
      if ((state_r != ST_FILL) && valid_r && ID_EX_MemRead && (ID_EX_rt != 5'd0) &&
          ((ID_EX_rt == rs_s) || (ID_EX_rt == rt_s))) begin
         hz_s = 1'b1;
      end else begin
         hz_s = 1'b0;
      end
   end

   assign stall_s  = hz_s & ~flush;
   assign PC_write = ~stall_s;
   assign bubble   = stall_s;

   // Next-state selection; a flush always returns to RUN
   always_comb begin
      next_state_s = ST_RUN;
      case (state_r)
         ST_FILL:  next_state_s = ST_RUN;
         ST_RUN:   next_state_s = stall_s ? ST_STALL : ST_RUN;
         ST_STALL: next_state_s = stall_s ? ST_STALL : ST_RUN;
         default:  next_state_s = ST_FILL;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_FILL;
      end else begin
         state_r <= next_state_s;
      end
   end

   // IF/ID contents: flush beats stall, stall holds, otherwise load from fetch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_r <= NOP_WORD;
         pc_r    <= 32'h0000_0000;
         valid_r <= 1'b0;
      end else if (flush) begin
         instr_r <= NOP_WORD;
         pc_r    <= PC_sumado_value;
         valid_r <= 1'b0;
      end else if (hz_s) begin
         instr_r <= instr_r;
         pc_r    <= pc_r;
         valid_r <= valid_r;
      end else begin
         instr_r <= Instruction;
         pc_r    <= PC_sumado_value;
         valid_r <= (state_r != ST_FILL);
      end
   end

   // Saturating stall counter, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= {CNT_W{1'b0}};
      end else if (stall_s && !count_max_s) begin
         count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign IF_ID_instruction = instr_r;
   assign IF_ID_pc_plus4    = pc_r;
   assign IF_ID_valid       = valid_r;
   assign stall_count       = count_r;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed plus randomized bench for if_id_stage, checked against a
// cycle-level behavioural model of the IF/ID register and hazard rules.
module tb_if_id_stage;

   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instruction = 32'h0;
   logic [31:0] pc_in = 32'h0;
   logic        flush = 1'b0;
   logic        memread = 1'b0;
   logic [4:0]  ex_rt = 5'd0;
   logic        pc_write;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_valid;
   logic        bubble;
   logic [15:0] stall_count;

   int checks = 0;
   int errors = 0;

   // model state
   logic [31:0] m_instr;
   logic [31:0] m_pc;
   logic        m_valid;
   logic [15:0] m_count;
   logic        m_fill;

   if_id_stage #(.NOP_WORD(NOP), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .Instruction(instruction), .PC_sumado_value(pc_in),
      .flush(flush), .ID_EX_MemRead(memread), .ID_EX_rt(ex_rt), .PC_write(pc_write),
      .IF_ID_instruction(if_instr), .IF_ID_pc_plus4(if_pc), .IF_ID_valid(if_valid),
      .bubble(bubble), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_instr = NOP; m_pc = 32'h0; m_valid = 1'b0; m_count = 16'h0; m_fill = 1'b1;
   endtask

   function automatic logic model_hz(input logic mr, input logic [4:0] r);
      return !m_fill && m_valid && mr && (r != 5'd0) &&
             ((r == m_instr[25:21]) || (r == m_instr[20:16]));
   endfunction

   task automatic check_regs(input string tag);
      chk({tag, ".instr"}, if_instr, m_instr);
      chk({tag, ".pc"}, if_pc, m_pc);
      chk({tag, ".valid"}, 32'(if_valid), 32'(m_valid));
      chk({tag, ".count"}, 32'(stall_count), 32'(m_count));
   endtask

   // one clock: drive at negedge, check combinational outputs, advance model, check registers
   task automatic step(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic mr, input logic [4:0] r);
      logic stall;
      @(negedge clk);
      instruction = ins; pc_in = pc; flush = fl; memread = mr; ex_rt = r;
      #1;
      stall = model_hz(mr, r) && !fl;
      chk({tag, ".pc_write"}, 32'(pc_write), 32'(!stall));
      chk({tag, ".bubble"}, 32'(bubble), 32'(stall));
      @(posedge clk);
      if (fl) begin
         m_instr = NOP; m_pc = pc; m_valid = 1'b0;
      end else if (stall) begin
         if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
      end else begin
         m_instr = ins; m_pc = pc; m_valid = !m_fill;
      end
      m_fill = 1'b0;
      #1;
      check_regs(tag);
   endtask

   initial begin
      int pick;
      int tmp;
      logic [4:0] r;
      model_reset();
      #3;
      check_regs("reset");
      chk("reset.pc_write", 32'(pc_write), 32'h1);
      chk("reset.bubble", 32'(bubble), 32'h0);
      @(posedge clk); #2 rst_n = 1'b1;

      // fill cycle: loaded but invalid, so a matching load must not stall
      step("fill", 32'h0022_1820, 32'h0, 1'b0, 1'b0, 5'd0);
      step("novalid", 32'h0022_1820, 32'h4, 1'b0, 1'b1, 5'd1);
      step("first", 32'h8C01_0000, 32'h4, 1'b0, 1'b0, 5'd0);
      step("normal1", 32'h0022_1820, 32'h8, 1'b0, 1'b0, 5'd0);
      // load-use on rs=1
      step("lu_rs", 32'h1111_1111, 32'hC, 1'b0, 1'b1, 5'd1);
      step("resume", 32'h1111_1111, 32'hC, 1'b0, 1'b0, 5'd0);
      // rs=0 instruction, load to r0: no hazard
      step("load_r0", 32'h0000_1820, 32'h10, 1'b0, 1'b0, 5'd0);
      step("no_false", 32'h0022_1820, 32'h14, 1'b0, 1'b1, 5'd0);
      // load-use on rt=2 with concurrent flush
      step("flush_hz", 32'h2222_2222, 32'h18, 1'b1, 1'b1, 5'd2);
      step("after_fl", 32'h0022_1820, 32'h1C, 1'b0, 1'b1, 5'd0);

      for (int i = 0; i < 400; i++) begin
         pick = $urandom_range(0, 3);
         r = (pick == 0) ? m_instr[25:21] : (pick == 1) ? m_instr[20:16] : 5'($urandom);
         step("rand", $urandom, $urandom, ($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 1)), r);
         if (i == 200) begin
            #2 rst_n = 1'b0;
            #1;
            model_reset();
            check_regs("midreset");
            chk("midreset.pc_write", 32'(pc_write), 32'h1);
            chk("midreset.bubble", 32'(bubble), 32'h0);
            @(posedge clk); #2 rst_n = 1'b1;
            step("mr_fill", 32'h0022_1820, 32'h0, 1'b0, 1'b0, 5'd0);
            step("mr_first", 32'h0022_1820, 32'h4, 1'b0, 1'b0, 5'd0);
         end
      end

      // saturation: hold a hazard well past 2^16 stall cycles
      step("sat_load", 32'h0022_1820, 32'h40, 1'b0, 1'b0, 5'd0);
      @(negedge clk);
      memread = 1'b1; ex_rt = 5'd1; flush = 1'b0;
      repeat (65540) @(posedge clk);
      #1;
      tmp = int'(m_count) + 65540;
      m_count = (tmp > 65535) ? 16'hFFFF : 16'(tmp);
      check_regs("sat");
      chk("sat.pc_write", 32'(pc_write), 32'h0);
      chk("sat.bubble", 32'(bubble), 32'h1);
      step("sat_hold", 32'h0022_1820, 32'h44, 1'b0, 1'b1, 5'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

IF/ID pipeline boundary of the five-stage pipeline, placed directly downstream of the instruction-fetch block. Each cycle it latches the fetched instruction and the incremented PC (`PC_sumado_value`). It also contains the load-use hazard detector, which generates the fetch block's `PC_write` and the bubble request for the ID/EX control mux. Taken-branch/jump flushes discard the latched instruction and replace it with a NOP.

## Interface
- `NOP_WORD`, default 32'h0000_0000: instruction word loaded on reset and on flush.
- `CNT_W`, default 16: width of the saturating stall counter.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `Instruction`  in  32: instruction word from the fetch block.
- `PC_sumado_value`  in  32: PC+4 from the fetch block.
- `flush`  in  1: taken branch/jump resolved downstream; kill the instruction in IF/ID.
- `ID_EX_MemRead`  in  1: the instruction in ID/EX is a load.
- `ID_EX_rt`  in  5: destination register of that load.
- `PC_write`  out  1: PC update enable to the fetch block.
- `IF_ID_instruction`  out  32: latched instruction.
- `IF_ID_pc_plus4`  out  32: latched PC+4.
- `IF_ID_valid`  out  1: latched instruction is real (not reset, fill or flush filler).
- `bubble`  out  1: zero the ID/EX control fields this cycle.
- `stall_count`  out  `CNT_W`: number of stall cycles since reset, saturating.

## Operation
- Register fields: rs = `IF_ID_instruction[25:21]`, rt = `IF_ID_instruction[20:16]`.
- Hazard (combinational), `hz` is true when all of the following hold:
  - `IF_ID_valid`
  - `ID_EX_MemRead`
  - `ID_EX_rt != 0`
  - `ID_EX_rt == rs` or `ID_EX_rt == rt`
- State machine, three states:
  - FILL: entered on reset; lasts one cycle.
  - RUN: normal flow.
  - STALL: hazard being serviced.
- Transitions:
  - FILL → RUN on the first clock edge after `rst_n` rises.
  - RUN → STALL when `hz` is true and `flush` is false.
  - STALL → RUN when `hz` is false or `flush` is true.
  - STALL → STALL when `hz` remains true (a dependent load followed by another load re-arms the stall).
- Per-cycle action. Priority order: reset, then flush, then hazard, then normal.
  - flush: IF/ID ← {`NOP_WORD`, `PC_sumado_value`}; `IF_ID_valid` ← 0; `PC_write` = 1; `bubble` = 0. Flush overrides a concurrent hazard.
  - hz (no flush): IF/ID holds its contents; `PC_write` = 0; `bubble` = 1; `stall_count` increments unless it is all-ones.
  - normal: IF/ID ← {`Instruction`, `PC_sumado_value`}; `IF_ID_valid` ← 1, except in FILL; `PC_write` = 1; `bubble` = 0.
- In FILL, `IF_ID_valid` stays 0 and the hazard is masked, so the fetch block's first synchronous read is discarded.
- `stall_count` saturates at 2^`CNT_W`−1 and never wraps. It is cleared only by reset.

## Timing
- Reset (asynchronous, immediate on `rst_n` low, mid-operation included):
  - `IF_ID_instruction` = `NOP_WORD`
  - `IF_ID_pc_plus4` = 0
  - `IF_ID_valid` = 0
  - `stall_count` = 0
  - state = FILL
  - `PC_write` = 1, `bubble` = 0 while in reset
- `PC_write` and `bubble` are combinational from the current IF/ID contents and the ID/EX inputs. They are valid in the same cycle as the hazard and settle before the next edge.
- IF/ID latency: one cycle from `Instruction`/`PC_sumado_value` to `IF_ID_*`.
- A load-use hazard costs exactly one stall cycle. The load moves to EX/MEM on the next edge, so `ID_EX_MemRead` drops and `hz` clears.
- `flush` takes effect on the edge that samples it. There is no extra fill cycle after a flush.

## Test plan
- Reset: drive `rst_n`=0 mid-stream. Outputs go to `NOP_WORD`, 0, 0, 0 immediately. After release, the first edge gives `IF_ID_valid`=0; from the second edge on it is 1, with `IF_ID_pc_plus4`=4 when `PC_sumado_value`=4.
- Normal flow: feed 0x8C010000, then 0x00221820, with `ID_EX_MemRead`=0. These appear on `IF_ID_instruction` one cycle later each; `PC_write`=1 and `bubble`=0 throughout.
- Load-use on rs: IF/ID holds 0x00221820 (rs=1), with `ID_EX_MemRead`=1 and `ID_EX_rt`=1.
  - In that cycle: `PC_write`=0, `bubble`=1, IF/ID unchanged at the next edge, `stall_count`=1.
  - When `ID_EX_MemRead` drops next cycle, flow resumes.
- No false hazard: `ID_EX_rt`=0 with rs=0 and `ID_EX_MemRead`=1 gives no stall. The same holds with `IF_ID_valid`=0.
- Flush beats stall: a hazard and `flush`=1 in the same cycle give `PC_write`=1, `bubble`=0, `IF_ID_instruction`=`NOP_WORD` and `IF_ID_valid`=0 at the next edge. `stall_count` is unchanged.
- Saturation: hold the hazard for 65 540 cycles with `CNT_W`=16. `stall_count` reaches 16'hFFFF and stays there.
